// File: rtl/soc_design_dma_0_pkg.sv
// rtl/soc_design_dma_0_pkg.sv - shared constants and types for the dma_0 transfer controller
// Purpose: CSR word offsets, status/control bit positions and the sequencer state type.
// Ports: none (package).
package soc_design_dma_0_pkg;

    localparam logic [2:0] CSR_STATUS  = 3'd0;
    localparam logic [2:0] CSR_RADDR   = 3'd1;
    localparam logic [2:0] CSR_WADDR   = 3'd2;
    localparam logic [2:0] CSR_LENGTH  = 3'd3;
    localparam logic [2:0] CSR_CONTROL = 3'd6;

    localparam int ST_DONE     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_LEN_ZERO = 2;

    localparam int CTL_GO  = 0;
    localparam int CTL_IEN = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/soc_design_dma_0_occ_counter.sv
// rtl/soc_design_dma_0_occ_counter.sv - up/down count of words buffered between read and write masters
// Purpose: tracks FIFO occupancy and flags when the post-update count leaves no free slot.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clk_en_i       global enable; the count only moves when high
//   clr_i          load zero (start of a new transfer)
//   inc_i, dec_i   accepted read word / accepted write word this cycle
//   occ_o          registered occupancy
//   full_o         occupancy after this cycle's inc/dec has reached DEPTH
module soc_design_dma_0_occ_counter #(
    parameter int DEPTH = 32,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [OCC_W-1:0] occ_o,
    output logic             full_o
);

    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] occ_next;

    // A simultaneous inc and dec cancel, so occupancy is unchanged.
    assign occ_next = occ_q + OCC_W'(inc_i) - OCC_W'(dec_i);
    assign occ_d    = clr_i ? '0 : occ_next;
    assign full_o   = (occ_next >= DEPTH_C);
    assign occ_o    = occ_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else if (clk_en_i) begin
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/soc_design_dma_0_xfer_ctrl.sv
// rtl/soc_design_dma_0_xfer_ctrl.sv - dma_0 transfer sequencer: CSR file, address/length counters, done/irq
// Purpose: owns the channel CSRs, sequences one transfer from go to last written word,
//          feeds the read engine go/p1_done_read/p1_fifo_full and raises done/irq.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   clk_en                global enable for every register
//   csr_*                 Avalon-style CSR slave; csr_readdata registered, 1-cycle latency
//   go                    run enable to the read engine (high while RUN)
//   p1_done_read          no reads remain after this cycle
//   p1_fifo_full          no free FIFO slot after this cycle
//   inc_read, inc_write   word accepted by the read / write engine
//   read_address, write_address  live address counters
//   irq                   done & interrupt enable
module soc_design_dma_0_xfer_ctrl
    import soc_design_dma_0_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 13,
    parameter int FIFO_DEPTH = 32,
    parameter int BYTES_PW   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [2:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write_n,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              go,
    output logic              p1_done_read,
    output logic              p1_fifo_full,
    input  logic              inc_read,
    input  logic              inc_write,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] write_address,
    output logic              irq
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0]  LEN_STEP  = LEN_W'(BYTES_PW);
    localparam logic [LEN_W-1:0]  LEN_MASK  = ~LEN_W'(BYTES_PW - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PW);

    state_e             state_q, state_d;
    logic               ctrl_go_q, ctrl_go_d;
    logic               ien_q, ien_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  raddr_csr_q, raddr_csr_d;
    logic [ADDR_W-1:0]  waddr_csr_q, waddr_csr_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [LEN_W-1:0]   rd_len_q, rd_len_d;
    logic [LEN_W-1:0]   wr_len_q, wr_len_d;
    logic [ADDR_W-1:0]  read_address_q, read_address_d;
    logic [ADDR_W-1:0]  write_address_q, write_address_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [OCC_W-1:0]   occ;
    logic               running;
    logic               csr_wr, csr_rd;
    logic               wr_status, wr_raddr, wr_waddr, wr_length, wr_control;
    logic               rd_ok, wr_ok, last_wr, start;

    assign running    = (state_q == RUN);
    assign csr_wr     = csr_chipselect & ~csr_write_n;
    assign csr_rd     = csr_chipselect & csr_write_n;
    assign wr_status  = csr_wr & (csr_address == CSR_STATUS);
    assign wr_raddr   = csr_wr & (csr_address == CSR_RADDR);
    assign wr_waddr   = csr_wr & (csr_address == CSR_WADDR);
    assign wr_length  = csr_wr & (csr_address == CSR_LENGTH);
    assign wr_control = csr_wr & (csr_address == CSR_CONTROL);

    // Engine strobes that would underflow a counter are dropped here.
    assign rd_ok   = running & inc_read & (rd_len_q != '0);
    assign wr_ok   = running & inc_write & (occ != '0);
    assign last_wr = wr_ok & (wr_len_q == LEN_STEP);
    assign start   = ~running & wr_control & csr_writedata[CTL_GO] & (length_q != '0);

    soc_design_dma_0_occ_counter #(
        .DEPTH (FIFO_DEPTH),
        .OCC_W (OCC_W)
    ) u_occ (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en_i (clk_en),
        .clr_i    (start),
        .inc_i    (rd_ok),
        .dec_i    (wr_ok),
        .occ_o    (occ),
        .full_o   (p1_fifo_full)
    );

    always_comb begin
        state_d         = state_q;
        ctrl_go_d       = ctrl_go_q;
        ien_d           = ien_q;
        done_d          = done_q;
        raddr_csr_d     = raddr_csr_q;
        waddr_csr_d     = waddr_csr_q;
        length_d        = length_q;
        rd_len_d        = rd_len_q;
        wr_len_d        = wr_len_q;
        read_address_d  = read_address_q;
        write_address_d = write_address_q;
        rdata_d         = rdata_q;

        // Clear first so a same-cycle completion still leaves done set.
        if (wr_status) done_d = 1'b0;
        if (wr_control) ien_d = csr_writedata[CTL_IEN];

        unique case (state_q)
            IDLE: begin
                ctrl_go_d = 1'b0;
                if (wr_raddr)  raddr_csr_d = ADDR_W'(csr_writedata);
                if (wr_waddr)  waddr_csr_d = ADDR_W'(csr_writedata);
                if (wr_length) length_d    = csr_writedata[LEN_W-1:0] & LEN_MASK;
                if (wr_control && csr_writedata[CTL_GO]) begin
                    if (start) begin
                        state_d         = RUN;
                        ctrl_go_d       = 1'b1;
                        rd_len_d        = length_q;
                        wr_len_d        = length_q;
                        read_address_d  = raddr_csr_q;
                        write_address_d = waddr_csr_q;
                    end else begin
                        // Zero-length request completes without running.
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_ok) begin
                    read_address_d = read_address_q + ADDR_STEP;
                    rd_len_d       = rd_len_q - LEN_STEP;
                end
                if (wr_ok) begin
                    write_address_d = write_address_q + ADDR_STEP;
                    wr_len_d        = wr_len_q - LEN_STEP;
                end
                if (wr_control) ctrl_go_d = csr_writedata[CTL_GO];
                if (last_wr) begin
                    done_d    = 1'b1;
                    ctrl_go_d = 1'b0;
                    state_d   = IDLE;
                end else if (wr_control && !csr_writedata[CTL_GO]) begin
                    // Abort: counters and occupancy are left where they stopped.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (csr_rd) begin
            rdata_d = '0;
            case (csr_address)
                CSR_STATUS: begin
                    rdata_d[ST_DONE]     = done_q;
                    rdata_d[ST_BUSY]     = running;
                    rdata_d[ST_LEN_ZERO] = (length_q == '0);
                end
                CSR_RADDR:  rdata_d = 32'(raddr_csr_q);
                CSR_WADDR:  rdata_d = 32'(waddr_csr_q);
                CSR_LENGTH: rdata_d = 32'(length_q);
                CSR_CONTROL: begin
                    rdata_d[CTL_GO]  = ctrl_go_q;
                    rdata_d[CTL_IEN] = ien_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            ctrl_go_q       <= 1'b0;
            ien_q           <= 1'b0;
            done_q          <= 1'b0;
            raddr_csr_q     <= '0;
            waddr_csr_q     <= '0;
            length_q        <= '0;
            rd_len_q        <= '0;
            wr_len_q        <= '0;
            read_address_q  <= '0;
            write_address_q <= '0;
            rdata_q         <= '0;
        end else if (clk_en) begin
            state_q         <= state_d;
            ctrl_go_q       <= ctrl_go_d;
            ien_q           <= ien_d;
            done_q          <= done_d;
            raddr_csr_q     <= raddr_csr_d;
            waddr_csr_q     <= waddr_csr_d;
            length_q        <= length_d;
            rd_len_q        <= rd_len_d;
            wr_len_q        <= wr_len_d;
            read_address_q  <= read_address_d;
            write_address_q <= write_address_d;
            rdata_q         <= rdata_d;
        end
    end

    assign go            = running;
    assign irq           = done_q & ien_q;
    assign csr_readdata  = rdata_q;
    assign read_address  = read_address_q;
    assign write_address = write_address_q;
    assign p1_done_read  = (rd_len_q == '0) | ((rd_len_q == LEN_STEP) & inc_read);

    a_read_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(clk_en && running && inc_read && (rd_len_q == '0)));
    a_write_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(clk_en && running && inc_write && (occ == '0)));

endmodule

// File: tb/tb_soc_design_dma_0_xfer_ctrl.sv
// tb/tb_soc_design_dma_0_xfer_ctrl.sv - scoreboard bench for the dma_0 transfer sequencer
module tb_soc_design_dma_0_xfer_ctrl;

    localparam int DEPTH = 4;
    localparam int BPW   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic [2:0]  csr_address = '0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write_n = 1'b1;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        go, p1_done_read, p1_fifo_full, irq;
    logic        inc_read = 1'b0;
    logic        inc_write = 1'b0;
    logic [31:0] read_address, write_address;

    soc_design_dma_0_xfer_ctrl #(
        .ADDR_W(32), .LEN_W(13), .FIFO_DEPTH(DEPTH), .BYTES_PW(BPW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
        .csr_address(csr_address), .csr_chipselect(csr_chipselect),
        .csr_write_n(csr_write_n), .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata), .go(go), .p1_done_read(p1_done_read),
        .p1_fifo_full(p1_fifo_full), .inc_read(inc_read), .inc_write(inc_write),
        .read_address(read_address), .write_address(write_address), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: transfer tracked in words remaining, not byte counters.
    bit          m_busy, m_done, m_ien;
    logic [31:0] m_rcsr, m_wcsr, m_ra, m_wa;
    int          m_len, m_rrem, m_wrem, m_occ;

    function automatic string sel_name(int s);
        case (s)
            0: return "csr_readdata";
            1: return "go";
            2: return "irq";
            3: return "p1_done_read";
            4: return "p1_fifo_full";
            5: return "read_address";
            default: return "write_address";
        endcase
    endfunction

    function automatic logic [31:0] actual(int s);
        case (s)
            0: return csr_readdata;
            1: return {31'b0, go};
            2: return {31'b0, irq};
            3: return {31'b0, p1_done_read};
            4: return {31'b0, p1_fifo_full};
            5: return read_address;
            default: return write_address;
        endcase
    endfunction

    // Monitor: compares every expectation stamped for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].stamp <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (e.stamp != cyc || actual(e.sel) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s cycle=%0d got=%h want=%h", sel_name(e.sel), cyc,
                             actual(e.sel), e.exp);
                end
            end
        end
    end

    task automatic push(int stamp, int sel, logic [31:0] v);
        exp_t e;
        e.stamp = stamp; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] csr_value(int a);
        case (a)
            0: return {29'b0, m_len == 0, m_busy, m_done};
            1: return m_rcsr;
            2: return m_wcsr;
            3: return 32'(m_len);
            6: return {30'b0, m_ien, m_busy};
            default: return 32'h0;
        endcase
    endfunction

    task automatic push_cycle(bit ir, bit iw);
        int acc_r, acc_w;
        acc_r = (m_busy && ir && m_rrem > 0) ? 1 : 0;
        acc_w = (m_busy && iw && m_occ > 0) ? 1 : 0;
        push(cyc, 1, {31'b0, m_busy});
        push(cyc, 2, {31'b0, m_done & m_ien});
        push(cyc, 3, {31'b0, (m_rrem == 0) || (m_rrem == 1 && ir)});
        push(cyc, 4, {31'b0, (m_occ + acc_r - acc_w) >= DEPTH});
        push(cyc, 5, m_ra);
        push(cyc, 6, m_wa);
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_ien = 0;
        m_rcsr = '0; m_wcsr = '0; m_ra = '0; m_wa = '0;
        m_len = 0; m_rrem = 0; m_wrem = 0; m_occ = 0;
    endtask

    task automatic model_step(bit c, bit w_n, int a, logic [31:0] d, bit ir, bit iw);
        bit wr, acc_r, acc_w, fin, done_n;
        wr     = c && !w_n;
        acc_r  = m_busy && ir && m_rrem > 0;
        acc_w  = m_busy && iw && m_occ > 0;
        fin    = acc_w && m_wrem == 1;
        done_n = m_done;
        if (wr && a == 0) done_n = 0;
        if (m_busy) begin
            if (acc_r) begin m_ra += BPW; m_rrem--; m_occ++; end
            if (acc_w) begin m_wa += BPW; m_wrem--; m_occ--; end
            if (fin) begin
                done_n = 1; m_busy = 0;
            end else if (wr && a == 6 && !d[0]) begin
                m_busy = 0;
            end
        end else if (wr) begin
            case (a)
                1: m_rcsr = d;
                2: m_wcsr = d;
                3: m_len = int'(d & 32'h1FFC);
                6: if (d[0]) begin
                    if (m_len == 0) done_n = 1;
                    else begin
                        m_busy = 1; m_rrem = m_len / BPW; m_wrem = m_len / BPW;
                        m_ra = m_rcsr; m_wa = m_wcsr; m_occ = 0;
                    end
                end
                default: ;
            endcase
        end
        if (wr && a == 6) m_ien = d[1];
        m_done = done_n;
    endtask

    task automatic tick(bit c, bit w_n, int a, logic [31:0] d, bit ir, bit iw, bit ce);
        csr_chipselect = c; csr_write_n = w_n; csr_address = 3'(a);
        csr_writedata = d; inc_read = ir; inc_write = iw; clk_en = ce;
        push_cycle(ir, iw);
        if (ce && c && w_n) push(cyc + 1, 0, csr_value(a));
        @(posedge clk);
        if (ce) model_step(c, w_n, a, d, ir, iw);
        cyc++;
        #1;
    endtask

    task automatic idle();                     tick(0, 1, 0, 0, 0, 0, 1); endtask
    task automatic wr(int a, logic [31:0] d);  tick(1, 0, a, d, 0, 0, 1); endtask
    task automatic rd(int a);                  tick(1, 1, a, 0, 0, 0, 1); endtask
    task automatic rdw(bit ir, bit iw);        tick(0, 1, 0, 0, ir, iw, 1); endtask

    task automatic do_reset();
        reset_n = 1'b0;
        csr_chipselect = 0; csr_write_n = 1; inc_read = 0; inc_write = 0; clk_en = 1;
        model_reset();
        push_cycle(0, 0);
        push(cyc, 0, 32'h0);
        @(posedge clk);
        cyc++;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        idle();
        rd(0);
        rd(6);

        // 16-byte transfer: four reads (fills the 4-deep FIFO), then four writes.
        wr(1, 32'h100); wr(2, 32'h200); wr(3, 16); wr(6, 1);
        for (int i = 0; i < 4; i++) rdw(1, 0);
        for (int i = 0; i < 4; i++) rdw(0, 1);
        idle(); rd(0); rd(1);

        // Full boundary, balanced read/write at occupancy 3, then abort.
        wr(0, 0); wr(3, 64); wr(6, 1);
        for (int i = 0; i < 4; i++) rdw(1, 0);
        rdw(0, 1);
        rdw(1, 1);
        rd(6);
        wr(6, 0);
        rd(0); rd(6);

        // Single-word transfer with interrupt enabled, then status clear.
        wr(0, 0); wr(3, 4); wr(6, 3);
        idle(); rdw(1, 0); idle(); rdw(0, 1); idle(); rd(0);
        wr(0, 0); idle();

        // Length below one word truncates to zero: done without running.
        wr(3, 2); wr(6, 1); idle(); rd(0); rd(3); wr(0, 0);

        // Reset in the middle of a transfer.
        wr(1, 32'hFFFF_FFF8); wr(2, 32'h40); wr(3, 32); wr(6, 1);
        rdw(1, 0); rdw(1, 0); rdw(0, 1); rdw(1, 0);
        do_reset();
        idle(); rd(0); rd(1); rd(3); rd(6);

        // Randomized transfers with stalls, reads, ignored writes and aborts.
        for (int ep = 0; ep < 25; ep++) begin
            wr(1, $urandom); wr(2, $urandom);
            wr(3, $urandom_range(0, 80));
            wr(6, {30'b0, 1'($urandom_range(0, 1)), 1'b1});
            for (int n = 0; n < 400 && m_busy; n++) begin
                bit ir, iw, ce;
                int r;
                ir = (m_rrem > 0 && m_occ < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
                iw = (m_occ > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                ce = ($urandom_range(0, 9) != 0);
                r  = $urandom_range(0, 59);
                if (r == 0)
                    tick(1, 0, 6, {30'b0, m_ien, 1'b0}, ir, iw, ce);
                else if (r < 4)
                    tick(1, 1, (r == 1) ? 0 : (r == 2) ? 3 : 6, 0, ir, iw, ce);
                else if (r == 4)
                    tick(1, 0, 1, $urandom, ir, iw, ce);
                else
                    tick(0, 1, 0, 0, ir, iw, ce);
            end
            if (m_busy) wr(6, 0);
            rd(0); rd(2);
            wr(0, 0);
        end

        repeat (3) idle();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
